// File: rtl/forwarding_pkg.sv
// Operand-class encoding shared by the forwarding and hazard units.
package forwarding_pkg;

    typedef enum logic [1:0] {
        NoForward,
        ForwardExecute,
        ForwardDecode
    } forwarding_type_t;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, data-memory wait FSM with timeout,
// control-redirect flushes (deferred across a memory wait) and a stall counter.
module hazard_unit
    import forwarding_pkg::*;
#(
    parameter int unsigned N       = 5,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  forwarding_type_t       forwarding_type_id,
    input  forwarding_type_t       forwarding_type_ex,
    input  logic [N-1:0]           rs1_id,
    input  logic [N-1:0]           rs2_id,
    input  logic [N-1:0]           rd_ex,
    input  logic [N-1:0]           rd_mem,
    input  logic                   reg_we_ex,
    input  logic                   reg_we_mem,
    input  logic                   mem_rd_ex,
    input  logic                   mem_rd_mem,
    input  logic                   mem_req_mem,
    input  logic                   mem_ack,
    input  logic                   flush_req_ex,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   stall_mem,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   bubble_ex,
    output logic                   bubble_wb,
    output logic                   mem_fault,
    output logic [CNT_W-1:0]       stall_count
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StMemWait, StDrain} state_t;

    state_t             state_q, state_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               pending_flush_q, pending_flush_d;
    logic [CNT_W-1:0]   stall_count_q, stall_count_d;

    logic lu, lu_a, lu_b, ms, timeout_hit, leave_wait;

    // EX-stage class is carried for symmetry with the forwarding unit only.
    logic unused_fwd_ex;
    assign unused_fwd_ex = ^forwarding_type_ex;

    function automatic logic reg_match(input logic [N-1:0] rd, input logic [N-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

    assign lu_a = mem_rd_ex && reg_we_ex && forwarding_type_id != NoForward &&
                  (reg_match(rd_ex, rs1_id) || reg_match(rd_ex, rs2_id));
    // Branch operands are needed in ID, so a load still in MEM cannot be forwarded yet.
    assign lu_b = forwarding_type_id == ForwardDecode && mem_rd_mem && reg_we_mem &&
                  (reg_match(rd_mem, rs1_id) || reg_match(rd_mem, rs2_id));
    assign lu   = lu_a || lu_b;

    assign ms          = mem_req_mem && !mem_ack && state_q != StDrain;
    assign timeout_hit = wait_cnt_q == TimeoutCnt;
    assign leave_wait  = mem_ack || timeout_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            wait_cnt_q      <= '0;
            pending_flush_q <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            pending_flush_q <= pending_flush_d;
            stall_count_q   <= stall_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        pending_flush_d = pending_flush_q;
        case (state_q)
            StIdle: begin
                if (ms) begin
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end
            end
            StMemWait: begin
                pending_flush_d = pending_flush_q || flush_req_ex;
                if (leave_wait) begin
                    state_d    = (pending_flush_q || flush_req_ex) ? StDrain : StIdle;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDrain: begin
                pending_flush_d = 1'b0;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        bubble_wb = 1'b0;
        mem_fault = 1'b0;
        if (reset) begin
            case (state_q)
                StIdle: begin
                    if (ms) begin
                        {stall_if, stall_id, stall_ex, stall_mem, bubble_wb} = '1;
                    end else if (flush_req_ex) begin
                        {flush_if, flush_id, bubble_ex} = '1;
                    end else if (lu) begin
                        {stall_if, stall_id, bubble_ex} = '1;
                    end
                end
                StMemWait: begin
                    if (mem_ack) begin
                        // Stalls release in the ack cycle; nothing else issued here.
                    end else if (timeout_hit) begin
                        {stall_if, stall_id, stall_ex} = '1;
                        {bubble_wb, mem_fault}         = '1;
                    end else begin
                        {stall_if, stall_id, stall_ex, stall_mem, bubble_wb} = '1;
                    end
                end
                StDrain: begin
                    {flush_if, flush_id, bubble_ex} = '1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_if && stall_count_q != '1) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit (TIMEOUT overridden to 4).
module tb_hazard_unit;
    import forwarding_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    forwarding_type_t fwd_id, fwd_ex;
    logic [4:0]       rs1_id, rs2_id, rd_ex, rd_mem;
    logic             reg_we_ex, reg_we_mem, mem_rd_ex, mem_rd_mem;
    logic             mem_req_mem, mem_ack, flush_req_ex;
    logic             stall_if, stall_id, stall_ex, stall_mem;
    logic             flush_if, flush_id, bubble_ex, bubble_wb, mem_fault;
    logic [31:0]      stall_count;
    logic [8:0]       outs;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_unit #(.N(5), .TIMEOUT(4), .CNT_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .forwarding_type_id (fwd_id),
        .forwarding_type_ex (fwd_ex),
        .rs1_id             (rs1_id),
        .rs2_id             (rs2_id),
        .rd_ex              (rd_ex),
        .rd_mem             (rd_mem),
        .reg_we_ex          (reg_we_ex),
        .reg_we_mem         (reg_we_mem),
        .mem_rd_ex          (mem_rd_ex),
        .mem_rd_mem         (mem_rd_mem),
        .mem_req_mem        (mem_req_mem),
        .mem_ack            (mem_ack),
        .flush_req_ex       (flush_req_ex),
        .stall_if           (stall_if),
        .stall_id           (stall_id),
        .stall_ex           (stall_ex),
        .stall_mem          (stall_mem),
        .flush_if           (flush_if),
        .flush_id           (flush_id),
        .bubble_ex          (bubble_ex),
        .bubble_wb          (bubble_wb),
        .mem_fault          (mem_fault),
        .stall_count        (stall_count)
    );

    always #5 clock = ~clock;

    // Bit order: stall_if stall_id stall_ex stall_mem flush_if flush_id bubble_ex bubble_wb mem_fault
    assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id,
                   bubble_ex, bubble_wb, mem_fault};

    task automatic idle_inputs();
        fwd_id = NoForward;  fwd_ex = NoForward;
        rs1_id = '0; rs2_id = '0; rd_ex = '0; rd_mem = '0;
        reg_we_ex = 1'b0; reg_we_mem = 1'b0; mem_rd_ex = 1'b0; mem_rd_mem = 1'b0;
        mem_req_mem = 1'b0; mem_ack = 1'b0; flush_req_ex = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after the first active edge following release.
    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        mem_req_mem = 1'b1; flush_req_ex = 1'b1;
        mem_rd_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd3; rs1_id = 5'd3; fwd_id = ForwardExecute;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL reset_outs got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", stall_count);
        else n_pass++;
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL reset_idle got=%b exp=%b", outs, 9'b0);
        else n_pass++;
    endtask

    task automatic test_load_use_ex();
        apply_reset();
        mem_rd_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; fwd_id = ForwardExecute;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b110000100) $display("FAIL lu_ex_stall got=%b exp=%b", outs, 9'b110000100);
        else n_pass++;
        step();
        mem_rd_ex = 1'b0; reg_we_ex = 1'b0; rd_ex = '0;
        mem_rd_mem = 1'b1; reg_we_mem = 1'b1; rd_mem = 5'd5;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL lu_ex_release got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_count !== 32'd1) $display("FAIL lu_ex_count got=%0d exp=1", stall_count);
        else n_pass++;
    endtask

    task automatic test_decode_consumer();
        apply_reset();
        mem_rd_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd7;
        rs1_id = 5'd3; rs2_id = 5'd7; fwd_id = ForwardDecode;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b110000100) $display("FAIL dec_stall1 got=%b exp=%b", outs, 9'b110000100);
        else n_pass++;
        step();
        mem_rd_ex = 1'b0; reg_we_ex = 1'b0; rd_ex = '0;
        mem_rd_mem = 1'b1; reg_we_mem = 1'b1; rd_mem = 5'd7;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b110000100) $display("FAIL dec_stall2 got=%b exp=%b", outs, 9'b110000100);
        else n_pass++;
        step();
        mem_rd_mem = 1'b0; reg_we_mem = 1'b0; rd_mem = '0;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL dec_release got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_count !== 32'd2) $display("FAIL dec_count got=%0d exp=2", stall_count);
        else n_pass++;
    endtask

    task automatic test_x0_dest();
        apply_reset();
        mem_rd_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; fwd_id = ForwardExecute;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL x0_nostall got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        step();
        @(negedge clock);
        n_checks++;
        if (stall_count !== 32'd0) $display("FAIL x0_count got=%0d exp=0", stall_count);
        else n_pass++;
    endtask

    task automatic test_priority();
        apply_reset();
        // Flush beats load-use.
        mem_rd_ex = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd9; rs1_id = 5'd9; fwd_id = ForwardExecute;
        flush_req_ex = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b000011100) $display("FAIL prio_flush got=%b exp=%b", outs, 9'b000011100);
        else n_pass++;
        // Memory stall beats flush and load-use.
        mem_req_mem = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b111100010) $display("FAIL prio_ms got=%b exp=%b", outs, 9'b111100010);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        apply_reset();
        mem_req_mem = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b111100010) $display("FAIL mw_c0 got=%b exp=%b", outs, 9'b111100010);
        else n_pass++;
        step();
        flush_req_ex = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b111100010) $display("FAIL mw_c1_noflush got=%b exp=%b", outs, 9'b111100010);
        else n_pass++;
        step();
        flush_req_ex = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b111100010) $display("FAIL mw_c2 got=%b exp=%b", outs, 9'b111100010);
        else n_pass++;
        step();
        mem_ack = 1'b1;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL mw_ack got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_count !== 32'd3) $display("FAIL mw_count got=%0d exp=3", stall_count);
        else n_pass++;
        step();
        // New request during DRAIN must wait for IDLE.
        mem_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b000011100) $display("FAIL mw_drain got=%b exp=%b", outs, 9'b000011100);
        else n_pass++;
        step();
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b111100010) $display("FAIL mw_after_drain got=%b exp=%b", outs, 9'b111100010);
        else n_pass++;
    endtask

    task automatic test_timeout();
        apply_reset();
        mem_req_mem = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            @(negedge clock);
            n_checks++;
            if ({stall_mem, mem_fault} !== 2'b10)
                $display("FAIL to_wait%0d got=%b exp=%b", i, {stall_mem, mem_fault}, 2'b10);
            else n_pass++;
        end
        step();
        @(negedge clock);
        n_checks++;
        if ({stall_mem, bubble_wb, mem_fault} !== 3'b011)
            $display("FAIL to_fault got=%b exp=%b", {stall_mem, bubble_wb, mem_fault}, 3'b011);
        else n_pass++;
        step();
        mem_req_mem = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL to_idle got=%b exp=%b", outs, 9'b0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        mem_req_mem = 1'b1;
        step();
        flush_req_ex = 1'b1;
        step();
        flush_req_ex = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (outs !== 9'b0) $display("FAIL arst_outs got=%b exp=%b", outs, 9'b0);
        else n_pass++;
        n_checks++;
        if (stall_count !== 32'd0) $display("FAIL arst_count got=%0d exp=0", stall_count);
        else n_pass++;
        mem_req_mem = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0 || stall_count !== 32'd0)
            $display("FAIL arst_idle got=%b/%0d exp=%b/0", outs, stall_count, 9'b0);
        else n_pass++;
        // A stale pending flush would produce a DRAIN after this access.
        mem_req_mem = 1'b1;
        step();
        mem_ack = 1'b1;
        step();
        mem_req_mem = 1'b0; mem_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (outs !== 9'b0) $display("FAIL arst_no_pending got=%b exp=%b", outs, 9'b0);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use_ex();
        test_decode_consumer();
        test_x0_dest();
        test_priority();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Producer-side partner of the forwarding unit. It detects the hazards that forwarding cannot resolve: load-use, data-memory wait and control redirects.
- It generates the pipeline stall, flush and bubble controls.
- It sits beside the forwarding unit in the 5-stage core and consumes the same forwarding_type_t classification.
- It contains a data-memory wait FSM with timeout, a deferred-flush latch and a stall performance counter.

Parameters:
- N, 5, register index width.
- TIMEOUT, 255, maximum MEM_WAIT cycles before an access fault; 8-bit counter, legal range 1..255.
- CNT_W, 32, stall counter width.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- forwarding_type_id  in  forwarding_type_t  class of the instruction in ID.
- forwarding_type_ex  in  forwarding_type_t  class of the instruction in EX.
- rs1_id, rs2_id  in  N  ID source registers.
- rd_ex, rd_mem  in  N  destinations in EX and MEM.
- reg_we_ex, reg_we_mem  in  1  register write enables.
- mem_rd_ex, mem_rd_mem  in  1  instruction in EX / MEM is a load.
- mem_req_mem  in  1  MEM stage data-memory request.
- mem_ack  in  1  data-memory acknowledge, same-cycle capable.
- flush_req_ex  in  1  taken branch, jump or trap redirect resolved in EX.
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register.
- flush_if, flush_id  out  1  squash the stage register.
- bubble_ex, bubble_wb  out  1  insert a NOP into the EX or WB register.
- mem_fault  out  1  one-cycle pulse on MEM_WAIT timeout.
- stall_count  out  CNT_W  saturating count of cycles with stall_if=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait_cnt=0, pending_flush=0, stall_count=0.
  - Every output is 0 while reset is asserted.
- match(rd, rs) is true when rd!=0 and rd==rs.
- Load-use condition lu, combinational:
  - (A) mem_rd_ex && reg_we_ex && (match(rd_ex, rs1_id) || match(rd_ex, rs2_id)) && forwarding_type_id != NoForward.
  - (B) forwarding_type_id==ForwardDecode && mem_rd_mem && reg_we_mem && match on rd_mem.
  - A ForwardDecode consumer of a load in EX therefore stalls 2 cycles: A, then B.
- Memory stall condition ms = mem_req_mem && !mem_ack && state != DRAIN.
- Priority: ms > flush > lu.
- FSM states IDLE, MEM_WAIT, DRAIN.
- IDLE:
  - If ms: assert all four stalls plus bubble_wb in the same cycle (Mealy). Next state MEM_WAIT, wait_cnt=1.
  - Else if flush_req_ex: assert flush_if, flush_id and bubble_ex.
  - Else if lu: assert stall_if, stall_id and bubble_ex; EX and MEM advance.
- MEM_WAIT:
  - If mem_ack: stalls deassert in the same cycle and the state returns to IDLE. If pending_flush=1 the state goes to DRAIN instead.
  - Else if wait_cnt==TIMEOUT: pulse mem_fault, assert bubble_wb, stall_mem=0, and go to IDLE or DRAIN (same pending_flush rule).
  - Else: keep all stalls plus bubble_wb asserted and increment wait_cnt.
  - flush_req_ex seen in this state sets pending_flush. No flush is issued from MEM_WAIT.
- DRAIN (exactly 1 cycle):
  - Assert flush_if, flush_id and bubble_ex.
  - Clear pending_flush and return to IDLE.
  - A new memory request is ignored this cycle and is taken in IDLE on the next cycle.
- lu is fully suppressed whenever ms or any flush is active.
- stall_count increments on each cycle with stall_if=1 and saturates at all-ones.
- Reset in mid-MEM_WAIT returns the unit to IDLE immediately and drops pending_flush.

Test Plan:
- Load-use via EX: load x5 in EX (mem_rd_ex=1, reg_we_ex=1, rd_ex=5), ADD with rs1_id=5 and ForwardExecute in ID -> exactly 1 cycle of stall_if=stall_id=bubble_ex=1; stall_count=1.
- Decode consumer of a load: branch (ForwardDecode) with rs2_id=7 behind load x7 -> 2 consecutive stall cycles; stall_count=2.
- x0 destination: load to x0 with rs1_id=0 -> no stall; stall_count=0.
- Memory wait: mem_req_mem=1 with mem_ack low for 3 cycles -> all stalls and bubble_wb high for 3 cycles, low on the ack cycle; flush_req_ex pulsed during the wait -> DRAIN flush one cycle after the ack.
- Timeout: TIMEOUT=4, ack never arrives -> mem_fault pulses on the 4th wait cycle and the FSM returns to IDLE.
- Async reset: assert reset in MEM_WAIT -> outputs 0 immediately; after release the FSM is in IDLE, pending_flush=0, stall_count=0.
